// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and sizing helper for the UART transmitter
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Bits needed to count 0..limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        if (limit <= 2) begin
            return 1;
        end
        return $clog2(limit);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - divide-by-DIVISOR bit-period counter with synchronous clear
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = cnt_width(DIVISOR);
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt;

    // Count 0..DIVISOR-1 and wrap; held at zero while cleared so each frame starts at phase 0.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter (data width, parity, stop bits)
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int DIVISOR = CLOCK_FREQ / BAUD_RATE;
    localparam int BW      = cnt_width(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = (STOP_BITS == 2);
    localparam logic          HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic          ODD_PARITY = (PARITY == PARITY_ODD);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 pin_q, pin_d;
    logic                 tick;

    // Bit-period timer runs only while a frame is in flight.
    uart_baud_gen #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    // State, datapath and registered line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            pin_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            pin_q      <= pin_d;
        end
    end

    // Next-state and datapath updates; the line level is derived from the next state so it
    // changes on the same edge as the state and leaves the block straight from a flop.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_done    = 1'b0;
        pin_d      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_d    = tx_data;
                    parity_d   = ODD_PARITY ? ~^tx_data : ^tx_data;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        state_d    = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        tx_done = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:  pin_d = 1'b0;
            ST_DATA:   pin_d = shift_d[0];
            ST_PARITY: pin_d = parity_d;
            default:   pin_d = 1'b1;
        endcase
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign tx_busy  = (state_q != ST_IDLE);
    assign tx_pin   = pin_q;

endmodule
